// File: rtl/minimax_sram_arbiter.sv
// minimax_sram_arbiter
//   Shares four single-ported 512x32 SRAM banks (byte addresses 0x0000-0x1FFF)
//   between the minimax fetch port and its load/store port. One SRAM command
//   per cycle, fair alternation under contention, sub-word store handling.
//
// Optional feature macro: MINIMAX_ARB_RMW_EN
//   defined   : partial stores do read-modify-write (ack two cycles after issue)
//   undefined : partial stores write nothing and ack with d_err one cycle after issue
//
// Ports
//   clk, reset_n          clock shared with the SRAMs, async active-low reset
//   i_req/i_addr          fetch request (held until i_ack), byte address
//   i_ack/i_data          fetch completion pulse, halfword selected by i_addr[1]
//   d_req/d_we/d_addr     data request (held until d_ack), store flag, byte address
//   d_wdata/d_wmask       store data and byte enables
//   d_ack/d_rdata/d_err   completion pulse, load data, unsupported-partial-store flag
//   sram_en/sram_addr     one-hot bank enable (addr[12:11]), word address (addr[10:2])
//   sram_wen/sram_wdata   write enable and write data
//   sram_rdata            {bank3,bank2,bank1,bank0} read data, valid the cycle after en
module minimax_sram_arbiter #(
    parameter int unsigned PC_BITS = 13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_req,
    input  logic [PC_BITS-1:0] i_addr,
    output logic               i_ack,
    output logic [15:0]        i_data,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [31:0]        d_addr,
    input  logic [31:0]        d_wdata,
    input  logic [3:0]         d_wmask,
    output logic               d_ack,
    output logic [31:0]        d_rdata,
    output logic               d_err,
    output logic [3:0]         sram_en,
    output logic [8:0]         sram_addr,
    output logic               sram_wen,
    output logic [31:0]        sram_wdata,
    input  logic [127:0]       sram_rdata
);

    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, RMW_MERGE} state_t;

    state_t      state, state_nx;
    logic        last_grant_d;   // 1 = data side was granted most recently
    logic        issue_i, issue_d;
    logic        d_in_range, d_full, d_partial, d_access;

    logic [1:0]  bank_q;
    logic        half_q;
    logic        rd_hit_q;
    logic        err_q;
    logic [31:0] bank_word;

`ifdef MINIMAX_ARB_RMW_EN
    logic [8:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic [31:0] mask_bits;
`endif

    logic        unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[0], d_addr[1:0]};

    assign bank_word  = sram_rdata[{bank_q, 5'd0} +: 32];
    assign d_in_range = (d_addr[31:13] == '0);
    assign d_full     = (d_wmask == 4'hF);
    assign d_partial  = d_we && (d_wmask != 4'h0) && !d_full;

`ifdef MINIMAX_ARB_RMW_EN
    assign d_access   = d_in_range && (!d_we || d_full || d_partial);
    assign mask_bits  = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
`else
    assign d_access   = d_in_range && (!d_we || d_full);
`endif

    // Arbitration. A WAIT state only considers the other requester: the side
    // being acked still holds its req during the ack cycle.
    always_comb begin
        issue_i = 1'b0;
        issue_d = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (i_req && d_req) begin
                        issue_i = !last_grant_d;
                        issue_d = last_grant_d ? 1'b0 : 1'b1;
                        issue_i = last_grant_d;
                    end else begin
                        issue_i = i_req;
                        issue_d = d_req;
                    end
                end
                I_WAIT:  issue_d = d_req;
                D_WAIT:  issue_i = i_req;
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
        end else begin
            state <= state_nx;
            if (issue_i)
                last_grant_d <= 1'b0;
            else if (issue_d)
                last_grant_d <= 1'b1;
        end
    end

    // Next state
    always_comb begin
        state_nx = IDLE;
        if (issue_i) begin
            state_nx = I_WAIT;
        end else if (issue_d) begin
`ifdef MINIMAX_ARB_RMW_EN
            state_nx = (d_in_range && d_partial) ? RMW_MERGE : D_WAIT;
`else
            state_nx = D_WAIT;
`endif
        end else if (state == RMW_MERGE) begin
            state_nx = D_WAIT;
        end
    end

    // Request attributes captured at issue; later input changes are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q   <= '0;
            half_q   <= 1'b0;
            rd_hit_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef MINIMAX_ARB_RMW_EN
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
`endif
        end else if (issue_i) begin
            bank_q <= i_addr[12:11];
            half_q <= i_addr[1];
        end else if (issue_d) begin
            bank_q   <= d_addr[12:11];
            rd_hit_q <= d_in_range && !d_we;
`ifdef MINIMAX_ARB_RMW_EN
            err_q    <= 1'b0;
            addr_q   <= d_addr[10:2];
            wdata_q  <= d_wdata;
            mask_q   <= d_wmask;
`else
            err_q    <= d_in_range && d_partial;
`endif
        end
    end

    // Outputs: acks come from the WAIT state, the new command from the issue
    // decision, so an ack and the next issue can share a cycle.
    always_comb begin
        i_ack      = 1'b0;
        i_data     = '0;
        d_ack      = 1'b0;
        d_rdata    = '0;
        d_err      = 1'b0;
        sram_en    = '0;
        sram_addr  = '0;
        sram_wen   = 1'b0;
        sram_wdata = '0;

        case (state)
            I_WAIT: begin
                i_ack  = 1'b1;
                i_data = half_q ? bank_word[31:16] : bank_word[15:0];
            end
            D_WAIT: begin
                d_ack   = 1'b1;
                d_rdata = rd_hit_q ? bank_word : '0;
                d_err   = err_q;
            end
`ifdef MINIMAX_ARB_RMW_EN
            RMW_MERGE: begin
                sram_en    = 4'b0001 << bank_q;
                sram_addr  = addr_q;
                sram_wen   = 1'b1;
                sram_wdata = (bank_word & ~mask_bits) | (wdata_q & mask_bits);
            end
`endif
            default: ;
        endcase

        if (issue_i) begin
            sram_en   = 4'b0001 << i_addr[12:11];
            sram_addr = i_addr[10:2];
        end else if (issue_d && d_access) begin
            sram_en   = 4'b0001 << d_addr[12:11];
            sram_addr = d_addr[10:2];
            if (d_we && d_full) begin
                sram_wen   = 1'b1;
                sram_wdata = d_wdata;
            end
        end
    end

endmodule
